regfile_wb_scoreboard: RTL and testbench
========================================

Name: regfile_wb_scoreboard

Overview:
- 16-entry x DATA_W register file with write-back scoreboard. Sits directly downstream of the 4-to-16 destination decoder.
- Consumes the decoder's one-hot enable twice:
  - at issue, to mark a destination register pending;
  - at write-back, to select the register to write and clear its pending bit.
- Provides two registered read ports with write-through bypass.
- Raises a stall when an operand is still pending.

Parameters:
- DATA_W, 16, register and data width in bits.
- NREG, 16, number of registers. Fixed by the 16-bit one-hot enable; not to be overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- wb_valid  input  1  write-back request this cycle.
- wb_enable  input  16  one-hot destination enable from decoder (write-back).
- wb_data  input  DATA_W  write-back data.
- iss_valid  input  1  instruction issue this cycle.
- iss_enable  input  16  one-hot destination enable from decoder (issue).
- rd_addr_a  input  4  read port A register index.
- rd_addr_b  input  4  read port B register index.
- rd_data_a  output  DATA_W  registered read data A.
- rd_data_b  output  DATA_W  registered read data B.
- pending  output  16  scoreboard, bit i = register i awaiting write-back.
- stall  output  1  operand hazard, combinational.
- onehot_err  output  1  sticky illegal-enable flag.
- err_clr  input  1  synchronous clear of onehot_err.

Behaviour:
- Reset (rst_n low, asynchronous) clears to 0:
  - all 16 registers;
  - rd_data_a, rd_data_b;
  - pending;
  - onehot_err.
  - stall follows from pending = 0, so it is 0.
- Legal enable: exactly one bit set. Zero or multi-hot is illegal.
- Write-back, on clk rising edge when wb_valid=1 and wb_enable is legal:
  - reg[i] <= wb_data, where i is the set bit;
  - pending[i] <= 0, unless the issue rule below sets it again.
- Illegal write-back (wb_valid=1, wb_enable not one-hot):
  - no register written and pending unchanged;
  - onehot_err <= 1.
- Issue, when iss_valid=1 and iss_enable is legal: pending <= pending | iss_enable.
- Illegal issue (iss_valid=1, iss_enable not one-hot):
  - pending unchanged;
  - onehot_err <= 1.
- Same register issued and written back in the same cycle: pending bit ends 1 (the new issue wins).
- Different registers issued and written back in the same cycle: both updates apply.
- onehot_err:
  - sticky;
  - err_clr=1 clears it next edge;
  - a new error in the same cycle as err_clr wins, so the flag stays 1.
- Reads:
  - latency 1 cycle: rd_data_x <= reg[rd_addr_x] at each rising edge;
  - no read enable; outputs update every cycle.
- Bypass: if a legal write-back targets rd_addr_x in the same cycle, rd_data_x <= wb_data, not the old value. Both ports bypass independently, including when rd_addr_a == rd_addr_b.
- stall (combinational):
  - stall = (pending[rd_addr_a] | pending[rd_addr_b]) & ~bypass_hit;
  - bypass_hit = a legal write-back this cycle to the pending register being read;
  - if both read registers are pending, stall stays 1 unless both are satisfied by this write-back.
- The block does not gate issue. The upstream controller holds iss_valid low while stall=1.
- Reset mid-operation discards all in-flight pending state. No write occurs on the reset edge.

Test Plan:
- Reset → rd_data_a/rd_data_b, pending and onehot_err all 0; stall=0 with rd_addr_a=rd_addr_b=0.
- iss_enable=16'h0020 with iss_valid → pending=16'h0020. Next cycle with rd_addr_a=5 → stall=1. Write-back wb_enable=16'h0020, wb_data=16'hBEEF that cycle → stall=0 same cycle; next edge rd_data_a=16'hBEEF and pending=0.
- Same-cycle issue and write-back both on 16'h0100 → pending[8] remains 1; reg8 holds wb_data.
- wb_valid with wb_enable=16'h0003 → no register changes and onehot_err=1. Then err_clr → onehot_err=0. Repeat with wb_enable=16'h0000 → onehot_err=1.
- Write 16'h1234 to reg3, then rd_addr_a=rd_addr_b=3 → both outputs 16'h1234 after 1 cycle. Write 16'h5678 to reg3 while reading it → outputs 16'h5678 at that edge (bypass).
- Pulse rst_n low mid-sequence with pending=16'hFFFF → pending=0 immediately (asynchronous), before the next clk edge.

Source files
------------

// File: rtl/regfile_wb_scoreboard.sv
// 16-entry register file with a write-back scoreboard, two registered read ports with
// write-through bypass, a combinational operand-hazard stall, and a sticky one-hot error flag.
module regfile_wb_scoreboard #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned NREG   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wb_valid,
    input  logic [NREG-1:0]   wb_enable,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              iss_valid,
    input  logic [NREG-1:0]   iss_enable,
    input  logic [3:0]        rd_addr_a,
    input  logic [3:0]        rd_addr_b,
    output logic [DATA_W-1:0] rd_data_a,
    output logic [DATA_W-1:0] rd_data_b,
    output logic [NREG-1:0]   pending,
    output logic              stall,
    output logic              onehot_err,
    input  logic              err_clr
);

    function automatic logic is_onehot(logic [NREG-1:0] v);
        return (v != '0) && ((v & (v - NREG'(1))) == '0);
    endfunction

    logic [DATA_W-1:0] regs_q [NREG];
    logic [DATA_W-1:0] rd_a_q, rd_a_d, rd_b_q, rd_b_d;
    logic [NREG-1:0]   pending_q, pending_d;
    logic              err_q, err_d;

    logic wb_ok, iss_ok, wb_bad, iss_bad;
    logic hit_a, hit_b;

    assign wb_ok   = wb_valid & is_onehot(wb_enable);
    assign iss_ok  = iss_valid & is_onehot(iss_enable);
    assign wb_bad  = wb_valid & ~is_onehot(wb_enable);
    assign iss_bad = iss_valid & ~is_onehot(iss_enable);

    // A port whose register is being written this cycle is satisfied by the bypass.
    assign hit_a = wb_ok & wb_enable[rd_addr_a];
    assign hit_b = wb_ok & wb_enable[rd_addr_b];

    assign stall = (pending_q[rd_addr_a] & ~hit_a) | (pending_q[rd_addr_b] & ~hit_b);

    always_comb begin
        pending_d = pending_q;
        if (wb_ok) begin
            pending_d = pending_d & ~wb_enable;
        end
        // Applied after the clear so a same-register issue wins.
        if (iss_ok) begin
            pending_d = pending_d | iss_enable;
        end

        err_d = err_q;
        if (err_clr) begin
            err_d = 1'b0;
        end
        if (wb_bad || iss_bad) begin
            err_d = 1'b1;
        end

        rd_a_d = hit_a ? wb_data : regs_q[rd_addr_a];
        rd_b_d = hit_b ? wb_data : regs_q[rd_addr_b];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NREG); i++) begin
                regs_q[i] <= '0;
            end
            rd_a_q    <= '0;
            rd_b_q    <= '0;
            pending_q <= '0;
            err_q     <= 1'b0;
        end else begin
            for (int i = 0; i < int'(NREG); i++) begin
                if (wb_ok && wb_enable[i]) begin
                    regs_q[i] <= wb_data;
                end
            end
            rd_a_q    <= rd_a_d;
            rd_b_q    <= rd_b_d;
            pending_q <= pending_d;
            err_q     <= err_d;
        end
    end

    assign rd_data_a  = rd_a_q;
    assign rd_data_b  = rd_b_q;
    assign pending    = pending_q;
    assign onehot_err = err_q;

endmodule

// File: tb/tb_regfile_wb_scoreboard.sv
// Bench for regfile_wb_scoreboard: directed scenarios followed by random traffic, all checked
// against an array-based reference model of the register file and scoreboard.
module tb_regfile_wb_scoreboard;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wb_valid;
    logic [15:0] wb_enable;
    logic [15:0] wb_data;
    logic        iss_valid;
    logic [15:0] iss_enable;
    logic [3:0]  rd_addr_a;
    logic [3:0]  rd_addr_b;
    logic [15:0] rd_data_a;
    logic [15:0] rd_data_b;
    logic [15:0] pending;
    logic        stall;
    logic        onehot_err;
    logic        err_clr;

    regfile_wb_scoreboard #(
        .DATA_W(16),
        .NREG  (16)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wb_valid  (wb_valid),
        .wb_enable (wb_enable),
        .wb_data   (wb_data),
        .iss_valid (iss_valid),
        .iss_enable(iss_enable),
        .rd_addr_a (rd_addr_a),
        .rd_addr_b (rd_addr_b),
        .rd_data_a (rd_data_a),
        .rd_data_b (rd_data_b),
        .pending   (pending),
        .stall     (stall),
        .onehot_err(onehot_err),
        .err_clr   (err_clr)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    int unsigned m_reg [16];
    bit          m_pend [16];
    bit          m_err;
    int unsigned m_rd_a, m_rd_b;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int onehot_index(input logic [15:0] v);
        if ($countones(v) != 1) return -1;
        for (int i = 0; i < 16; i++) if (v[i]) return i;
        return -1;
    endfunction

    function automatic logic [15:0] pend_vec();
        logic [15:0] v = '0;
        for (int i = 0; i < 16; i++) v[i] = m_pend[i];
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
            m_reg[i]  = 0;
            m_pend[i] = 0;
        end
        m_err  = 0;
        m_rd_a = 0;
        m_rd_b = 0;
    endtask

    function automatic bit model_stall();
        int w = wb_valid ? onehot_index(wb_enable) : -1;
        bit sa = m_pend[rd_addr_a] && (w != int'(rd_addr_a));
        bit sb = m_pend[rd_addr_b] && (w != int'(rd_addr_b));
        return sa || sb;
    endfunction

    task automatic model_tick();
        int w = wb_valid ? onehot_index(wb_enable) : -1;
        int s = iss_valid ? onehot_index(iss_enable) : -1;
        m_rd_a = (w == int'(rd_addr_a)) ? wb_data : m_reg[rd_addr_a];
        m_rd_b = (w == int'(rd_addr_b)) ? wb_data : m_reg[rd_addr_b];
        if (w >= 0) begin
            m_reg[w]  = wb_data;
            m_pend[w] = 0;
        end
        if (s >= 0) m_pend[s] = 1;
        if ((wb_valid && w < 0) || (iss_valid && s < 0)) m_err = 1;
        else if (err_clr) m_err = 0;
    endtask

    task automatic drive(input logic wv, input logic [15:0] we, input logic [15:0] wd,
                         input logic iv, input logic [15:0] ie,
                         input logic [3:0] ra, input logic [3:0] rb, input logic clr);
        wb_valid = wv; wb_enable = we; wb_data = wd;
        iss_valid = iv; iss_enable = ie;
        rd_addr_a = ra; rd_addr_b = rb; err_clr = clr;
    endtask

    // Called at a negedge with inputs already driven; returns at the following negedge.
    task automatic cycle(input string tag);
        #1;
        check({tag, "_stall"}, stall, model_stall());
        model_tick();
        @(posedge clk);
        #1;
        check({tag, "_rda"}, rd_data_a, m_rd_a[15:0]);
        check({tag, "_rdb"}, rd_data_b, m_rd_b[15:0]);
        check({tag, "_pend"}, pending, pend_vec());
        check({tag, "_err"}, onehot_err, m_err);
        @(negedge clk);
    endtask

    function automatic logic [15:0] rand_enable();
        int unsigned r = $urandom_range(0, 9);
        logic [15:0] v;
        if (r < 8) v = 16'(1) << $urandom_range(0, 15);
        else if (r == 8) v = '0;
        else v = 16'($urandom);
        return v;
    endfunction

    initial begin
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        model_reset();
        @(negedge clk);
        check("rst_rda", rd_data_a, 0);
        check("rst_rdb", rd_data_b, 0);
        check("rst_pend", pending, 0);
        check("rst_err", onehot_err, 0);
        check("rst_stall", stall, 0);
        rst_n = 1'b1;

        // Issue r5, then read it (stall), then write it back with bypass
        drive(0, 0, 0, 1, 16'h0020, 0, 0, 0);           cycle("iss5");
        check("iss5_pendval", pending, 16'h0020);
        drive(0, 0, 0, 0, 0, 5, 0, 0);                  #1;
        check("r5_stall_hi", stall, 1);
        drive(1, 16'h0020, 16'hBEEF, 0, 0, 5, 0, 0);    #1;
        check("r5_stall_lo", stall, 0);
        cycle("wb5");
        check("wb5_rdval", rd_data_a, 16'hBEEF);
        check("wb5_pendval", pending, 0);

        // Same-cycle issue and write-back on r8
        drive(1, 16'h0100, 16'hA5A5, 1, 16'h0100, 8, 8, 0); cycle("same8");
        check("same8_pend", pending, 16'h0100);
        drive(0, 0, 0, 0, 0, 8, 0, 0);                  cycle("rd8");
        check("rd8_val", rd_data_a, 16'hA5A5);

        // Illegal write-backs and err_clr
        drive(1, 16'h0003, 16'hDEAD, 0, 0, 0, 1, 0);    cycle("ill3");
        check("ill3_err", onehot_err, 1);
        drive(0, 0, 0, 0, 0, 0, 1, 0);                  cycle("ill3_rd");
        drive(0, 0, 0, 0, 0, 0, 0, 1);                  cycle("clr");
        check("clr_err", onehot_err, 0);
        drive(1, 16'h0000, 16'hDEAD, 0, 0, 0, 0, 0);    cycle("ill0");
        check("ill0_err", onehot_err, 1);
        drive(1, 16'h0000, 0, 0, 0, 0, 0, 1);           cycle("clr_vs_err");
        check("clr_vs_err_val", onehot_err, 1);
        drive(0, 0, 0, 1, 16'h0C00, 0, 0, 0);           cycle("iss_multi");
        drive(0, 0, 0, 0, 0, 0, 0, 1);                  cycle("clr2");

        // Read-after-write and bypass on r3
        drive(1, 16'h0008, 16'h1234, 0, 0, 0, 0, 0);    cycle("w3");
        drive(0, 0, 0, 0, 0, 3, 3, 0);                  cycle("r3");
        check("r3_a", rd_data_a, 16'h1234);
        check("r3_b", rd_data_b, 16'h1234);
        drive(1, 16'h0008, 16'h5678, 0, 0, 3, 3, 0);    cycle("byp3");
        check("byp3_a", rd_data_a, 16'h5678);
        check("byp3_b", rd_data_b, 16'h5678);

        // Both ports pending, one satisfied: stall must remain
        drive(0, 0, 0, 1, 16'h0002, 0, 0, 0);           cycle("iss1");
        drive(0, 0, 0, 1, 16'h0004, 0, 0, 0);           cycle("iss2");
        drive(1, 16'h0002, 16'h0101, 0, 0, 1, 2, 0);    cycle("half");
        drive(1, 16'h0004, 16'h0202, 0, 0, 1, 2, 0);    cycle("full");

        // Fill the scoreboard, then reset asynchronously between edges
        for (int i = 0; i < 16; i++) begin
            drive(0, 0, 0, 1, 16'(1) << i, 0, 0, 0);
            cycle("fill");
        end
        check("fill_pend", pending, 16'hFFFF);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check("async_pend", pending, 0);
        check("async_rda", rd_data_a, 0);
        check("async_stall", stall, 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int n = 0; n < 600; n++) begin
            drive($urandom_range(0, 1), rand_enable(), 16'($urandom),
                  $urandom_range(0, 2) == 0, rand_enable(),
                  4'($urandom), 4'($urandom), $urandom_range(0, 7) == 0);
            cycle("rand");
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running expected=finished");
        $fatal(1);
    end

endmodule
